// File: rtl/ram_be_pkg.sv
// Shared types and helpers for the byte-enable synchronous RAM.
package ram_be_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic bit data_w_ok(input int unsigned data_w);
    return (data_w % BYTE_W) == 0;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sweep sequencer: drives array clear writes, ready and cmd_err.
module ram_clear_seq
  import ram_be_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready,
  output logic              cmd_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  ram_state_e       state, state_nx;
  logic [CNT_W-1:0] clr_cnt, cnt_nx;
  logic             ready_nx;
  logic             cmd_err_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= cnt_nx;
      ready   <= ready_nx;
      cmd_err <= cmd_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = clr_cnt;
    cmd_err_nx = (wr_en | rd_en) & ~ready;
    case (state)
      CLEAR: begin
        cnt_nx = clr_cnt + CNT_W'(1);
        if (clr_cnt == CNT_W'(DEPTH - 1)) state_nx = READY;
      end
      READY:   state_nx = READY;
      default: state_nx = CLEAR;
    endcase
    ready_nx = (state_nx == READY);
  end

  // Reset itself must never disturb the array contents.
  assign clr_we   = (state == CLEAR) & ~reset;
  assign clr_addr = clr_cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_be_sync.sv
// Single-clock RAM with byte enables, registered read-first read port and
// hardware clear sweep after reset.
module ram_be_sync
  import ram_be_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                ready,
  output logic                cmd_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BE_W  = be_w(DATA_W);

  if (!data_w_ok(DATA_W)) begin : g_width_check
    $fatal(1, "ram_be_sync: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              rd_ok;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready),
    .cmd_err  (cmd_err)
  );

  assign wr_ok = wr_en & ready & ~reset;
  assign rd_ok = rd_en & ready & ~reset;

  // Clear sweep owns the array until ready; user writes are byte-lane gated.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else if (wr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Non-blocking array update above makes same-edge reads return old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) rdata <= mem[addr];
    end
  end

endmodule

// File: tb/tb_ram_be_sync.sv
// Directed self-checking bench for ram_be_sync (16 x 32, INIT_VAL DEAD_BEEF).
module tb_ram_be_sync;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] INIT   = 32'hDEAD_BEEF;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              ready;
  logic              cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  ram_be_sync #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .ready   (ready),
    .cmd_err (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // Counts cycles from release until ready; returns 0 on timeout.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ready === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if ({ready, rvalid, cmd_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/rvalid/cmd_err=%b want 000", {ready, rvalid, cmd_err});
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want 00000000", rdata);
    end
    reset = 1'b0;
    wait_ready(cyc);
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL clear_latency: got %0d want 16 (0 = timeout)", cyc);
    end
  endtask

  task automatic test_read_init();
    for (int i = 0; i < DEPTH; i++) begin
      addr = 4'(i); rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== INIT) begin
        n_fail++;
        $display("FAIL init_read[%0d]: got rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, INIT);
      end
      step();
      n_checks++;
      if (rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL init_rvalid_pulse[%0d]: got %b want 0", i, rvalid);
      end
    end
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 32'h1122_3344, 4'b1111);
    do_write(4'd3, 32'hAABB_CCDD, 4'b0101);
    addr = 4'd3; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL be_merge: got rvalid=%b rdata=%h want 1 11bb33dd", rvalid, rdata);
    end
    step();
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL be_rvalid_pulse: got %b want 0", rvalid);
    end
    do_write(4'd3, 32'hFFFF_FFFF, 4'b0000);
    addr = 4'd3; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (rdata !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL be_zero_noop: got %h want 11bb33dd", rdata);
    end
  endtask

  task automatic test_read_during_write();
    addr = 4'd5; wdata = 32'h0000_0001; be = 4'hF;
    wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== INIT) begin
      n_fail++;
      $display("FAIL rdw_old: got rvalid=%b rdata=%h want 1 %h", rvalid, rdata, INIT);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL rdw_new: got rvalid=%b rdata=%h want 1 00000001", rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) do_write(4'(i), 32'(i), 4'hF);
    for (int i = 0; i < DEPTH; i++) begin
      addr = 4'(i); rd_en = 1'b1;
      step();
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'(i)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, 32'(i));
      end
    end
    rd_en = 1'b0;
    step();
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_cmd_err();
    int cyc;
    do_write(4'd9, 32'h1234_5678, 4'hF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step();
    addr = 4'd9; wdata = 32'h5555_5555; be = 4'hF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (cmd_err !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_err_wr: got cmd_err=%b rvalid=%b want 1 0", cmd_err, rvalid);
    end
    step();
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_err_pulse: got %b want 0", cmd_err);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (cmd_err !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_err_rd: got cmd_err=%b rvalid=%b want 1 0", cmd_err, rvalid);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 10) begin
      n_fail++;
      $display("FAIL cmd_err_ready: got %0d more cycles want 10 (0 = timeout)", cyc);
    end
    addr = 4'd9; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== INIT) begin
      n_fail++;
      $display("FAIL cmd_err_addr9: got rvalid=%b rdata=%h want 1 %h", rvalid, rdata, INIT);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    for (int i = 0; i < DEPTH; i++) do_write(4'(i), 32'hA5A5_0000 | 32'(i), 4'hF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 7; n++) step();
    rd_en = 1'b1;
    reset = 1'b1;
    step();
    rd_en = 1'b0;
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b0 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: got ready=%b cmd_err=%b want 0 0", ready, cmd_err);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL mid_reset_latency: got %0d want 16 (0 = timeout)", cyc);
    end
    for (int i = 0; i < DEPTH; i++) begin
      addr = 4'(i); rd_en = 1'b1;
      step();
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== INIT) begin
        n_fail++;
        $display("FAIL mid_reset_read[%0d]: got rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, INIT);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_ready_reset_drop();
    reset = 1'b1;
    addr = 4'd0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL ready_reset: got ready=%b rvalid=%b rdata=%h want 0 0 00000000", ready, rvalid, rdata);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wdata = '0; be = '0;
    test_reset();
    test_read_init();
    test_byte_enable();
    test_read_during_write();
    test_back_to_back();
    test_cmd_err();
    test_reset_mid_sweep();
    test_ready_reset_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
